dht11_reader: RTL and testbench
===============================

Name: dht11_reader

Overview:
- Single-wire DHT11 protocol master; sits directly upstream of the LCD driver and feeds its BCD digit inputs.
- On a start request it issues the host start pulse, captures the 40-bit sensor frame and verifies the checksum.
- Converts integral humidity and temperature bytes to 3-digit BCD by sequential double-dabble.
- Presents stable digits that are updated only on a good frame.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; CLK_HZ/1_000_000 must be ≥1 (µs prescaler divisor).
- START_LOW_US, 18000, duration the host holds the line low.
- TIMEOUT_US, 200, maximum wait in any sensor-driven phase before abort.
- BIT1_THRESH_US, 50, high-phase length above which a data bit is 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to read the sensor; ignored while busy=1
- dht_in  in  1  raw data-line level (asynchronous)
- dht_oe  out  1  1 = drive line low (external open-drain), 0 = release
- busy  out  1  transaction in progress
- valid  out  1  one-cycle pulse when new values are latched
- err  out  2  [0] timeout, [1] checksum mismatch; sticky until next accepted start
- hum_int  out  8  last good humidity integral byte
- temp_int  out  8  last good temperature integral byte
- hum_hundreds, hum_tens, hum_units  out  4 each  BCD of hum_int
- temp_hundreds, temp_tens, temp_units  out  4 each  BCD of temp_int

Behaviour:
- Reset (async, rst_n=0): state IDLE; dht_oe=0, busy=0, valid=0, err=0, all data/BCD outputs 0; prescaler, µs counter, bit counter and shift register cleared.
- dht_in passes through a 2-flop synchronizer; all edge decisions use the synchronized value (2-cycle latency).
- A µs tick is generated every CLK_HZ/1_000_000 clocks. A µs counter clears on every state change and saturates at its maximum.
- FSM states and transitions:
  - IDLE: start=1 → START_LOW and clear err. Otherwise stay.
  - START_LOW: dht_oe=1; after START_LOW_US → RELEASE.
  - RELEASE: dht_oe=0; line low → RESP_LOW.
  - RESP_LOW: line high → RESP_HIGH.
  - RESP_HIGH: line low → BIT_LOW with bit count 0.
  - BIT_LOW: line high → BIT_HIGH.
  - BIT_HIGH: line low → shift in bit (1 if µs count > BIT1_THRESH_US, else 0), MSB first, and increment count. Count 40 → CHECK, else → BIT_LOW.
  - CHECK: checksum = (b0+b1+b2+b3) mod 256 compared with b4. Match → CONVERT. Mismatch → set err[1] → IDLE.
  - CONVERT: 8 iterations, one per clock, of add-3-if-≥5 then shift, run on both bytes in parallel → DONE.
  - DONE: latch hum_int=b0, temp_int=b2 and all six BCD digits; valid=1 for this cycle → IDLE.
- Timeout: in RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH, µs count ≥ TIMEOUT_US → set err[0], dht_oe=0, go to IDLE. The last frame is left incomplete.
- busy=1 in every state except IDLE. start is ignored when busy=1.
- Decimal bytes b1 and b3 are captured but not output.
- Outputs hold their previous good values through errors, timeouts and in-flight transactions. BCD outputs change only in the DONE cycle, and all simultaneously.
- hundreds digit range 0-2 (max 255 → 2,5,5).
- Reset asserted mid-transaction: line released immediately (dht_oe=0); outputs return to reset values.
- A frame arriving while IDLE is ignored (no edge processing outside the active states).

Test Plan:
- Sensor model frame 0x37,0x00,0x19,0x00,0x50 after a start pulse → one valid pulse; hum_int=55 with digits 0,5,5; temp_int=25 with digits 0,2,5; err=00; busy falls the same cycle valid pulses.
- Same frame with checksum 0x51 → no valid pulse; err=10; outputs keep the prior values 55/25.
- Start with no sensor response (line held high) → dht_oe low for START_LOW_US, then err=01 after TIMEOUT_US in RELEASE; busy=0.
- Frame 0xFF,0x00,0xFF,0x00,0xFE → digits 2,5,5 for both; bit decoding checked at high times of 27 µs (0) and 70 µs (1).
- start pulsed again mid-frame → ignored, frame completes normally; rst_n pulled low during BIT_HIGH → dht_oe=0, all outputs 0 asynchronously, FSM back in IDLE.
- Run with CLK_HZ=1_000_000 (1 clock per µs) and a line stuck low after bit 20 → err=01 and outputs unchanged.

Source files
------------

// File: rtl/dht11_reader.sv
// DHT11 single-wire master: host start pulse, 40-bit frame capture with checksum,
// and sequential binary-to-BCD conversion of the integral humidity/temperature bytes.
module dht11_reader #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int START_LOW_US   = 18000,
  parameter int TIMEOUT_US     = 200,
  parameter int BIT1_THRESH_US = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       valid,
  output logic [1:0] err,
  output logic [7:0] hum_int,
  output logic [7:0] temp_int,
  output logic [3:0] hum_hundreds,
  output logic [3:0] hum_tens,
  output logic [3:0] hum_units,
  output logic [3:0] temp_hundreds,
  output logic [3:0] temp_tens,
  output logic [3:0] temp_units
);

  // state     | meaning
  // IDLE      | waiting for start
  // START_LOW | host drives line low
  // RELEASE   | line released, wait for sensor to pull low
  // RESP_LOW  | sensor response low phase
  // RESP_HIGH | sensor response high phase
  // BIT_LOW   | data bit low preamble
  // BIT_HIGH  | data bit high phase, length decides the bit
  // CHECK     | checksum compare
  // CONVERT   | 8 double-dabble iterations
  // DONE      | latch outputs

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int M1  = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int M2  = (M1 > BIT1_THRESH_US) ? M1 : BIT1_THRESH_US;
  localparam int UW  = $clog2(M2 + 2);

  typedef enum logic [3:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH,
    BIT_LOW, BIT_HIGH, CHECK, CONVERT, DONE
  } state_t;

  state_t state, state_next;

  logic          sync1, sync2, line_d;
  logic          rise, fall;
  logic [PW-1:0] presc;
  logic          tick;
  logic [UW-1:0] us_cnt;
  logic [5:0]    bit_cnt;
  logic [39:0]   shreg;
  logic [2:0]    conv_cnt;
  logic [11:0]   bcd_h, bcd_t, adj_h, adj_t;
  logic [7:0]    bin_h, bin_t;
  logic [7:0]    sum;
  logic          sensor_phase;
  logic          set_to, set_ck, clr_err, shift_en, load_conv;

  function automatic logic [11:0] dd_adj(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  assign rise  = sync2 & ~line_d;
  assign fall  = ~sync2 & line_d;
  assign tick  = (presc == '0);
  assign sum   = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  assign adj_h = dd_adj(bcd_h);
  assign adj_t = dd_adj(bcd_t);
  assign sensor_phase = (state == RELEASE) || (state == RESP_LOW) || (state == RESP_HIGH) ||
                        (state == BIT_LOW) || (state == BIT_HIGH);

  // Sync flops idle high so reset release never looks like a line edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_d <= 1'b1;
    end else begin
      sync1  <= dht_in;
      sync2  <= sync1;
      line_d <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      us_cnt <= '0;
    end else begin
      presc <= tick ? PW'(DIV - 1) : presc - 1'b1;
      if (state_next != state)
        us_cnt <= '0;
      else if (tick && (us_cnt != '1))
        us_cnt <= us_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    set_to     = 1'b0;
    set_ck     = 1'b0;
    clr_err    = 1'b0;
    shift_en   = 1'b0;
    load_conv  = 1'b0;
    if (sensor_phase && (us_cnt >= UW'(TIMEOUT_US))) begin
      set_to     = 1'b1;
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          clr_err    = 1'b1;
          state_next = START_LOW;
        end
        START_LOW: if (us_cnt >= UW'(START_LOW_US)) state_next = RELEASE;
        RELEASE:   if (fall) state_next = RESP_LOW;
        RESP_LOW:  if (rise) state_next = RESP_HIGH;
        RESP_HIGH: if (fall) state_next = BIT_LOW;
        BIT_LOW:   if (rise) state_next = BIT_HIGH;
        BIT_HIGH: if (fall) begin
          shift_en   = 1'b1;
          state_next = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
        end
        CHECK: if (sum == shreg[7:0]) begin
          load_conv  = 1'b1;
          state_next = CONVERT;
        end else begin
          set_ck     = 1'b1;
          state_next = IDLE;
        end
        CONVERT: if (conv_cnt == 3'd0) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign dht_oe = (state == START_LOW);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      conv_cnt <= '0;
      bcd_h    <= '0;
      bcd_t    <= '0;
      bin_h    <= '0;
      bin_t    <= '0;
    end else begin
      if (state == RESP_HIGH)
        bit_cnt <= '0;
      else if (shift_en)
        bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)
        shreg <= {shreg[38:0], (us_cnt > UW'(BIT1_THRESH_US))};
      if (load_conv) begin
        bin_h    <= shreg[39:32];
        bin_t    <= shreg[23:16];
        bcd_h    <= '0;
        bcd_t    <= '0;
        conv_cnt <= 3'd7;
      end else if (state == CONVERT) begin
        bcd_h    <= {adj_h[10:0], bin_h[7]};
        bcd_t    <= {adj_t[10:0], bin_t[7]};
        bin_h    <= {bin_h[6:0], 1'b0};
        bin_t    <= {bin_t[6:0], 1'b0};
        conv_cnt <= conv_cnt - 1'b1;
      end
    end
  end

  // Outputs update together at the end of DONE, so valid and the new values share one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid         <= 1'b0;
      err           <= '0;
      hum_int       <= '0;
      temp_int      <= '0;
      hum_hundreds  <= '0;
      hum_tens      <= '0;
      hum_units     <= '0;
      temp_hundreds <= '0;
      temp_tens     <= '0;
      temp_units    <= '0;
    end else begin
      valid <= (state == DONE);
      if (clr_err) begin
        err <= '0;
      end else begin
        if (set_to) err[0] <= 1'b1;
        if (set_ck) err[1] <= 1'b1;
      end
      if (state == DONE) begin
        hum_int       <= shreg[39:32];
        temp_int      <= shreg[23:16];
        hum_hundreds  <= bcd_h[11:8];
        hum_tens      <= bcd_h[7:4];
        hum_units     <= bcd_h[3:0];
        temp_hundreds <= bcd_t[11:8];
        temp_tens     <= bcd_t[7:4];
        temp_units    <= bcd_t[3:0];
      end
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
// Scoreboard bench for dht11_reader: a sensor model drives frames, each transaction's
// expected outcome is queued and checked when busy falls.
`timescale 1ns/1ps
module tb_dht11_reader;

  typedef struct packed {
    logic        vld;
    logic [1:0]  err;
    logic [7:0]  hum;
    logic [7:0]  temp;
    logic [23:0] dig;
  } exp_t;

  int checks = 0;
  int failures = 0;
  exp_t q1[$];
  exp_t q2[$];

  logic clk1 = 0, clk2 = 0;
  logic rst_n1, rst_n2, start1, start2, sdrv1, sdrv2;
  logic oe1, busy1, valid1, oe2, busy2, valid2;
  logic [1:0] err1, err2;
  logic [7:0] hum1, temp1, hum2, temp2;
  logic [3:0] hh1, ht1, hu1, th1, tt1, tu1, hh2, ht2, hu2, th2, tt2, tu2;
  logic [23:0] dig1, dig2;
  logic din1, din2;

  always #250 clk1 = ~clk1;
  always #500 clk2 = ~clk2;

  assign din1 = oe1 ? 1'b0 : sdrv1;
  assign din2 = oe2 ? 1'b0 : sdrv2;
  assign dig1 = {hh1, ht1, hu1, th1, tt1, tu1};
  assign dig2 = {hh2, ht2, hu2, th2, tt2, tu2};

  dht11_reader #(.CLK_HZ(2_000_000), .START_LOW_US(100), .TIMEOUT_US(200), .BIT1_THRESH_US(50)) dut1 (
    .clk(clk1), .rst_n(rst_n1), .start(start1), .dht_in(din1), .dht_oe(oe1), .busy(busy1),
    .valid(valid1), .err(err1), .hum_int(hum1), .temp_int(temp1),
    .hum_hundreds(hh1), .hum_tens(ht1), .hum_units(hu1),
    .temp_hundreds(th1), .temp_tens(tt1), .temp_units(tu1));

  dht11_reader #(.CLK_HZ(1_000_000), .START_LOW_US(100), .TIMEOUT_US(200), .BIT1_THRESH_US(50)) dut2 (
    .clk(clk2), .rst_n(rst_n2), .start(start2), .dht_in(din2), .dht_oe(oe2), .busy(busy2),
    .valid(valid2), .err(err2), .hum_int(hum2), .temp_int(temp2),
    .hum_hundreds(hh2), .hum_tens(ht2), .hum_units(hu2),
    .temp_hundreds(th2), .temp_tens(tt2), .temp_units(tu2));

  function automatic exp_t mk(input logic v, input logic [1:0] e, input logic [7:0] h,
                              input logic [7:0] t, input logic [23:0] d);
    exp_t x;
    x.vld = v; x.err = e; x.hum = h; x.temp = t; x.dig = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_entry(input string tag, input exp_t o, input exp_t e);
    chk({tag, "_valid"}, 32'(o.vld), 32'(e.vld));
    chk({tag, "_err"},   32'(o.err), 32'(e.err));
    chk({tag, "_hum"},   32'(o.hum), 32'(e.hum));
    chk({tag, "_temp"},  32'(o.temp), 32'(e.temp));
    chk({tag, "_bcd"},   32'(o.dig), 32'(e.dig));
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) sdrv1 = v; else sdrv2 = v;
  endtask

  function automatic logic oe_of(input int sel);
    return (sel == 0) ? oe1 : oe2;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy1 : busy2;
  endfunction

  task automatic wait_us(input int n);
    #(n * 1000);
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) begin
      @(posedge clk1); #1 start1 = 1'b1;
      @(posedge clk1); #1 start1 = 1'b0;
    end else begin
      @(posedge clk2); #1 start2 = 1'b1;
      @(posedge clk2); #1 start2 = 1'b0;
    end
  endtask

  task automatic do_reset1();
    rst_n1 = 1'b0;
    #1;
    chk("rst_mid_oe", 32'(oe1), 32'd0);
    chk("rst_mid_busy", 32'(busy1), 32'd0);
    chk("rst_mid_valid", 32'(valid1), 32'd0);
    chk("rst_mid_hum", 32'(hum1), 32'd0);
    chk("rst_mid_bcd", 32'(dig1), 32'd0);
    set_line(0, 1'b1);
    wait_us(3);
    @(negedge clk1) rst_n1 = 1'b1;
  endtask

  // stuck_after: -1 none, -2 no sensor response, n>=0 line held low from bit n on
  task automatic send_frame(input int sel, input logic [39:0] f, input int stuck_after,
                            input int start_at_bit, input int rst_at_bit);
    realtime t0, dt;
    pulse_start(sel);
    for (int k = 0; k < 2000 && !oe_of(sel); k++) #100;
    if (!oe_of(sel)) begin
      chk("oe_rise_timeout", 32'(oe_of(sel)), 32'd1);
      return;
    end
    t0 = $realtime;
    for (int k = 0; k < 20000 && oe_of(sel); k++) #100;
    dt = ($realtime - t0) / 1000.0;
    checks++;
    if (oe_of(sel) || dt < 98.5 || dt > 101.5) begin
      failures++;
      $display("FAIL start_low_len actual=%0.1fus required=100us", dt);
      return;
    end
    if (stuck_after == -2) begin
      wait_us(400);
      return;
    end
    wait_us(30);
    set_line(sel, 1'b0); wait_us(80);
    set_line(sel, 1'b1); wait_us(80);
    for (int i = 0; i < 40; i++) begin
      set_line(sel, 1'b0);
      if (i == stuck_after) begin
        wait_us(300);
        set_line(sel, 1'b1);
        return;
      end
      if (i == start_at_bit) pulse_start(sel);
      wait_us(50);
      set_line(sel, 1'b1);
      if (i == rst_at_bit) begin
        wait_us(10);
        do_reset1();
        return;
      end
      wait_us(f[39-i] ? 70 : 27);
    end
    set_line(sel, 1'b0); wait_us(50);
    set_line(sel, 1'b1);
  endtask

  task automatic wait_idle(input int sel);
    for (int k = 0; k < 2000 && busy_of(sel); k++) wait_us(1);
    if (busy_of(sel)) chk("idle_timeout", 32'(busy_of(sel)), 32'd0);
    wait_us(20);
  endtask

  initial begin : mon1
    logic pb;
    pb = 1'b0;
    forever begin
      @(negedge clk1);
      if (pb && !busy1) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL dut1_unexpected_end actual=1 required=0");
        end else begin
          check_entry("dut1", mk(valid1, err1, hum1, temp1, dig1), q1.pop_front());
        end
      end
      pb = busy1;
    end
  end

  initial begin : mon2
    logic pb;
    pb = 1'b0;
    forever begin
      @(negedge clk2);
      if (pb && !busy2) begin
        if (q2.size() == 0) begin
          checks++; failures++;
          $display("FAIL dut2_unexpected_end actual=1 required=0");
        end else begin
          check_entry("dut2", mk(valid2, err2, hum2, temp2, dig2), q2.pop_front());
        end
      end
      pb = busy2;
    end
  end

  initial begin : watchdog
    #70_000_000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst_n1 = 0; rst_n2 = 0; start1 = 0; start2 = 0; sdrv1 = 1; sdrv2 = 1;
    #3000;
    chk("rst_oe", 32'(oe1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_valid", 32'(valid1), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_data", 32'({hum1, temp1}), 32'd0);
    chk("rst_bcd", 32'(dig1), 32'd0);
    chk("rst2_busy", 32'(busy2), 32'd0);
    @(negedge clk1) rst_n1 = 1;
    @(negedge clk2) rst_n2 = 1;
    wait_us(5);
    fork
      begin
        q1.push_back(mk(1, 2'b00, 8'd55, 8'd25, 24'h055025));
        send_frame(0, 40'h37_00_19_00_50, -1, -1, -1); wait_idle(0);
        q1.push_back(mk(0, 2'b10, 8'd55, 8'd25, 24'h055025));
        send_frame(0, 40'h37_00_19_00_51, -1, -1, -1); wait_idle(0);
        q1.push_back(mk(0, 2'b01, 8'd55, 8'd25, 24'h055025));
        send_frame(0, 40'h0, -2, -1, -1); wait_idle(0);
        q1.push_back(mk(1, 2'b00, 8'd255, 8'd255, 24'h255255));
        send_frame(0, 40'hFF_00_FF_00_FE, -1, -1, -1); wait_idle(0);
        q1.push_back(mk(1, 2'b00, 8'd45, 8'd30, 24'h045030));
        send_frame(0, 40'h2D_03_1E_07_55, -1, 10, -1); wait_idle(0);
        q1.push_back(mk(0, 2'b00, 8'd0, 8'd0, 24'h000000));
        send_frame(0, 40'h37_00_19_00_50, -1, -1, 15); wait_idle(0);
        q1.push_back(mk(1, 2'b00, 8'd55, 8'd25, 24'h055025));
        send_frame(0, 40'h37_00_19_00_50, -1, -1, -1); wait_idle(0);
      end
      begin
        q2.push_back(mk(1, 2'b00, 8'd55, 8'd25, 24'h055025));
        send_frame(1, 40'h37_00_19_00_50, -1, -1, -1); wait_idle(1);
        q2.push_back(mk(0, 2'b01, 8'd55, 8'd25, 24'h055025));
        send_frame(1, 40'h19_00_37_00_50, 20, -1, -1); wait_idle(1);
      end
    join
    repeat (20) @(negedge clk2);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
